// File: rtl/enet_pll_lock_sequencer.sv
// enet_pll_lock_sequencer: brings up the Ethernet clock PLL, qualifies lock and gates MAC clock-select changes
module enet_pll_lock_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 500000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRIES  = 4,
    parameter int GATE_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sw_restart,
    input  logic       pll_locked,
    output logic       pll_rst,
    input  logic [1:0] spd_req,
    input  logic       spd_valid,
    output logic       spd_ready,
    output logic [1:0] clk_sel,
    output logic       mac_clk_en,
    output logic       mac_reset_n,
    output logic       pll_ready,
    output logic       pll_fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);
    localparam int M1   = RST_CYCLES > LOCK_TIMEOUT ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int M2   = LOCK_STABLE > GATE_CYCLES ? LOCK_STABLE : GATE_CYCLES;
    localparam int CMAX = M1 > M2 ? M1 : M2;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, GATE_PRE, GATE_POST, FAIL} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    lk_s;
    logic [1:0]    spd_tgt;
    logic          lk;
    logic          in_run;

    assign lk     = lk_s[1];
    assign in_run = state == RUN || state == GATE_PRE || state == GATE_POST;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= PLL_RST;
            cnt         <= '0;
            lk_s        <= '0;
            spd_tgt     <= 2'b10;
            pll_rst     <= 1'b1;
            spd_ready   <= 1'b0;
            clk_sel     <= 2'b10;
            mac_clk_en  <= 1'b0;
            mac_reset_n <= 1'b0;
            pll_ready   <= 1'b0;
            pll_fail    <= 1'b0;
            retry_cnt   <= '0;
            loss_cnt    <= '0;
        end else begin
            lk_s <= {lk_s[0], pll_locked};
            if (sw_restart) begin
                state       <= PLL_RST;
                cnt         <= '0;
                retry_cnt   <= '0;
                pll_fail    <= 1'b0;
                pll_rst     <= 1'b1;
                spd_ready   <= 1'b0;
                mac_clk_en  <= 1'b0;
                mac_reset_n <= 1'b0;
                pll_ready   <= 1'b0;
            end else if (in_run && !lk) begin
                // lock lost: an in-flight speed change is abandoned, clk_sel keeps its last value
                loss_cnt    <= loss_cnt + {7'd0, loss_cnt != 8'hff};
                state       <= PLL_RST;
                cnt         <= '0;
                pll_rst     <= 1'b1;
                spd_ready   <= 1'b0;
                mac_clk_en  <= 1'b0;
                mac_reset_n <= 1'b0;
                pll_ready   <= 1'b0;
            end else begin
                case (state)
                    PLL_RST: begin
                        if (cnt == CW'(RST_CYCLES - 1)) begin
                            state   <= WAIT_LOCK;
                            cnt     <= '0;
                            pll_rst <= 1'b0;
                        end else cnt <= cnt + CW'(1);
                    end
                    WAIT_LOCK: begin
                        if (lk) begin
                            // the cycle that sees lock counts as the first stable cycle
                            state <= STABLE;
                            cnt   <= CW'(1);
                        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                            retry_cnt <= retry_cnt + 4'd1;
                            cnt       <= '0;
                            pll_rst   <= 1'b1;
                            state     <= retry_cnt == 4'(MAX_RETRIES - 1) ? FAIL : PLL_RST;
                            pll_fail  <= retry_cnt == 4'(MAX_RETRIES - 1);
                        end else cnt <= cnt + CW'(1);
                    end
                    STABLE: begin
                        if (!lk) begin
                            state <= WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == CW'(LOCK_STABLE - 1)) begin
                            state       <= RUN;
                            retry_cnt   <= '0;
                            pll_ready   <= 1'b1;
                            mac_reset_n <= 1'b1;
                            mac_clk_en  <= 1'b1;
                            spd_ready   <= 1'b1;
                        end else cnt <= cnt + CW'(1);
                    end
                    RUN: begin
                        if (spd_valid && spd_ready && spd_req != 2'b11 && spd_req != clk_sel) begin
                            state      <= GATE_PRE;
                            spd_tgt    <= spd_req;
                            cnt        <= '0;
                            mac_clk_en <= 1'b0;
                            spd_ready  <= 1'b0;
                        end
                    end
                    GATE_PRE: begin
                        if (cnt == CW'(GATE_CYCLES - 1)) begin
                            state   <= GATE_POST;
                            clk_sel <= spd_tgt;
                            cnt     <= '0;
                        end else cnt <= cnt + CW'(1);
                    end
                    GATE_POST: begin
                        if (cnt == CW'(GATE_CYCLES - 1)) begin
                            state      <= RUN;
                            mac_clk_en <= 1'b1;
                            spd_ready  <= 1'b1;
                        end else cnt <= cnt + CW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
